// File: rtl/dcsk_demodulator_pkg.sv
// dcsk_pkg: shared DCSK FSM encoding, default sizes and accumulator width
package dcsk_pkg;
    typedef enum logic [1:0] {IDLE, REF, DATA} state_t;
    localparam int SF_DEFAULT = 8;
    localparam int SAMPLE_W_DEFAULT = 8;
    function automatic int acc_w(input int sf, input int sample_w);
        return 2 * sample_w + $clog2(sf);
    endfunction
endpackage

// File: rtl/dcsk_demodulator_chip_delay_line.sv
// chip_delay_line: SF-deep shift register of chips exposing the oldest tap
module chip_delay_line import dcsk_pkg::*; #(
    parameter int SF = SF_DEFAULT,
    parameter int SAMPLE_W = SAMPLE_W_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic signed [SAMPLE_W-1:0] sample,
    output logic signed [SAMPLE_W-1:0] oldest
);
    logic signed [SAMPLE_W-1:0] taps [SF];
    always_ff @(posedge clk)
        if (rst) begin
            for (int i = 0; i < SF; i++) taps[i] <= '0;
        end else if (en) begin
            taps[0] <= sample;
            for (int i = 1; i < SF; i++) taps[i] <= taps[i-1];
        end
    assign oldest = taps[SF-1];
endmodule

// File: rtl/dcsk_demodulator.sv
// dcsk_demodulator: correlates DCSK data half against the delayed reference half
module dcsk_demodulator import dcsk_pkg::*; #(
    parameter int SF = SF_DEFAULT,
    parameter int SAMPLE_W = SAMPLE_W_DEFAULT,
    localparam int ACC_W = acc_w(SF, SAMPLE_W)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic signed [SAMPLE_W-1:0] in_sample,
    input  logic                       sync,
    output logic                       out_valid,
    output logic                       out_bit,
    output logic signed [ACC_W-1:0]    out_corr
);
    localparam int CW = $clog2(SF);
    localparam logic [CW-1:0] LAST = CW'(SF - 1);
    state_t state;
    logic [CW-1:0] cnt;
    logic signed [ACC_W-1:0] acc, sum, chip, ref_chip;
    logic signed [SAMPLE_W-1:0] tap;
    logic last_data;
    assign chip = {{(ACC_W-SAMPLE_W){in_sample[SAMPLE_W-1]}}, in_sample};
    assign ref_chip = {{(ACC_W-SAMPLE_W){tap[SAMPLE_W-1]}}, tap};
    assign sum = acc + chip * ref_chip;
    assign last_data = state == DATA && cnt == LAST;
    chip_delay_line #(.SF(SF), .SAMPLE_W(SAMPLE_W)) delay (
        .clk(clk),
        .rst(rst),
        .en(in_valid && (sync || state != IDLE)),
        .sample(in_sample),
        .oldest(tap)
    );
    always_ff @(posedge clk)
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            acc <= '0;
            out_valid <= 1'b0;
            out_bit <= 1'b0;
            out_corr <= '0;
        end else begin
            out_valid <= in_valid && last_data;
            if (in_valid && last_data) begin
                out_corr <= sum;
                out_bit <= ~sum[ACC_W-1];
            end
            if (in_valid) begin
                if (sync) begin
                    state <= REF;
                    cnt <= CW'(1);
                    acc <= '0;
                end else if (state == REF) begin
                    state <= cnt == LAST ? DATA : REF;
                    cnt <= cnt == LAST ? '0 : cnt + CW'(1);
                end else if (state == DATA) begin
                    state <= last_data ? REF : DATA;
                    cnt <= last_data ? '0 : cnt + CW'(1);
                    acc <= last_data ? '0 : sum;
                end
            end
        end
endmodule

// File: tb/tb_dcsk_demodulator.sv
// tb_dcsk_demodulator: scoreboard bench for SF=4 and SF=8 demodulator instances
module tb_dcsk_demodulator;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst, v4, s4, v8, s8, ov4, ob4, ov8, ob8;
    logic signed [7:0] x4, x8;
    logic signed [17:0] oc4;
    logic signed [18:0] oc8;
    int checks = 0, errors = 0;
    int q4[$], q8[$];

    dcsk_demodulator #(.SF(4), .SAMPLE_W(8)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_sample(x4), .sync(s4),
        .out_valid(ov4), .out_bit(ob4), .out_corr(oc4));
    dcsk_demodulator #(.SF(8), .SAMPLE_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_sample(x8), .sync(s8),
        .out_valid(ov8), .out_bit(ob8), .out_corr(oc8));

    always @(negedge clk) if (ov4) begin
        int e;
        checks++;
        if (q4.size() == 0) begin
            errors++;
            $display("FAIL pulse4: unexpected out_valid, out_corr=%0d", oc4);
        end else begin
            e = q4.pop_front();
            if (oc4 !== e) begin errors++; $display("FAIL corr4: got %0d want %0d", oc4, e); end
            checks++;
            if (ob4 !== (e >= 0)) begin errors++; $display("FAIL bit4: got %0b want %0b", ob4, e >= 0); end
        end
    end

    always @(negedge clk) if (ov8) begin
        int e;
        checks++;
        if (q8.size() == 0) begin
            errors++;
            $display("FAIL pulse8: unexpected out_valid, out_corr=%0d", oc8);
        end else begin
            e = q8.pop_front();
            if (oc8 !== e) begin errors++; $display("FAIL corr8: got %0d want %0d", oc8, e); end
            checks++;
            if (ob8 !== (e >= 0)) begin errors++; $display("FAIL bit8: got %0b want %0b", ob8, e >= 0); end
        end
    end

    function automatic int dot(input int xs[$], input int off, input int sf);
        int s = 0;
        for (int i = 0; i < sf; i++) s += xs[off+i] * xs[off+sf+i];
        return s;
    endfunction

    task automatic play4(input int xs[$], input logic [31:0] sm, input int gap);
        foreach (xs[i]) begin
            @(negedge clk); v4 = 1'b1; s4 = sm[i]; x4 = 8'(xs[i]);
            repeat (gap) begin @(negedge clk); v4 = 1'b0; s4 = 1'b1; x4 = 8'sh7f; end
        end
    endtask

    task automatic play8(input int xs[$], input logic [31:0] sm);
        foreach (xs[i]) begin
            @(negedge clk); v8 = 1'b1; s8 = sm[i]; x8 = 8'(xs[i]);
        end
    endtask

    task automatic drain(input string name);
        @(negedge clk); v4 = 1'b0; s4 = 1'b0; v8 = 1'b0; s8 = 1'b0;
        for (int k = 0; k < 20 && (q4.size() != 0 || q8.size() != 0); k++) @(negedge clk);
        checks++;
        if (q4.size() != 0 || q8.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d/%0d results missing after timeout", name, q4.size(), q8.size());
        end
        q4.delete(); q8.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; v4 = 1'b1; s4 = 1'b1; x4 = 8'sd5; v8 = 1'b1; s8 = 1'b1; x8 = 8'sd5;
        repeat (2) @(negedge clk);
        rst = 1'b0; v4 = 1'b0; s4 = 1'b0; v8 = 1'b0; s8 = 1'b0;
        checks += 4;
        if (ov4 !== 1'b0 || ov8 !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b%b want 00", ov4, ov8); end
        if (ob4 !== 1'b0 || ob8 !== 1'b0) begin errors++; $display("FAIL reset_bit: got %b%b want 00", ob4, ob8); end
        if (oc4 !== 18'sd0) begin errors++; $display("FAIL reset_corr4: got %0d want 0", oc4); end
        if (oc8 !== 19'sd0) begin errors++; $display("FAIL reset_corr8: got %0d want 0", oc8); end
    endtask

    task automatic test_bit1();
        int xs[$] = {10, -20, 30, -40, 10, -20, 30, -40};
        q4.push_back(dot(xs, 0, 4));
        play4(xs, 32'h1, 0);
        drain("bit1");
    endtask

    task automatic test_back_to_back();
        int xs[$] = {10, -20, 30, -40, -10, 20, -30, 40, 1, 1, 1, 1, 0, 0, 0, 0};
        q4.push_back(dot(xs, 0, 4));
        q4.push_back(dot(xs, 8, 4));
        play4(xs, 32'h1, 0);
        drain("back_to_back");
        repeat (3) @(negedge clk);
        checks += 2;
        if (oc4 !== 18'sd0) begin errors++; $display("FAIL hold_corr: got %0d want 0", oc4); end
        if (ob4 !== 1'b1) begin errors++; $display("FAIL hold_bit: got %b want 1", ob4); end
    endtask

    task automatic test_gapped();
        int xs[$] = {10, -20, 30, -40, 10, -20, 30};
        int all[$] = {10, -20, 30, -40, 10, -20, 30, -40};
        q4.push_back(dot(all, 0, 4));
        play4(xs, 32'h1, 2);
        @(negedge clk); v4 = 1'b1; s4 = 1'b0; x4 = -8'sd40;
        @(negedge clk); v4 = 1'b0;
        checks++;
        if (ov4 !== 1'b1) begin errors++; $display("FAIL latency: out_valid got %b want 1", ov4); end
        @(negedge clk);
        checks++;
        if (ov4 !== 1'b0) begin errors++; $display("FAIL pulse_width: out_valid got %b want 0", ov4); end
        drain("gapped");
    endtask

    task automatic test_sync_abort();
        int xs[$] = {10, -20, 30, -40, 7, 7, 10, -20, 30, -40, 10, -20, 30, -40};
        q4.push_back(dot(xs, 6, 4));
        play4(xs, 32'h41, 0);
        drain("sync_abort");
    endtask

    task automatic test_sync_last();
        int xs[$] = {10, -20, 30, -40, 10, -20, 30, -40, 5, 6, 7, -40, 5, 6, 7};
        q4.push_back(dot(xs, 0, 4));
        q4.push_back(dot(xs, 7, 4));
        play4(xs, 32'h81, 0);
        drain("sync_last");
    endtask

    task automatic test_reset_mid();
        int part[$] = {10, -20, 30, -40, 10, -20, 30};
        int xs[$] = {10, -20, 30, -40, 10, -20, 30, -40};
        play4(part, 32'h1, 0);
        @(negedge clk); rst = 1'b1; v4 = 1'b1; s4 = 1'b0; x4 = -8'sd40;
        @(negedge clk); rst = 1'b0; v4 = 1'b0;
        checks += 3;
        if (ov4 !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", ov4); end
        if (ob4 !== 1'b0) begin errors++; $display("FAIL rst_mid_bit: got %b want 0", ob4); end
        if (oc4 !== 18'sd0) begin errors++; $display("FAIL rst_mid_corr: got %0d want 0", oc4); end
        play4(xs, 32'h0, 0);
        play4(xs, 32'h0, 1);
        @(negedge clk); v4 = 1'b0;
        repeat (4) @(negedge clk);
        q4.push_back(dot(xs, 0, 4));
        play4(xs, 32'h1, 0);
        drain("reset_mid");
    endtask

    task automatic test_extremes();
        int xs[$];
        for (int i = 0; i < 16; i++) xs.push_back(-128);
        for (int i = 0; i < 8; i++) xs.push_back(127);
        for (int i = 0; i < 8; i++) xs.push_back(-128);
        q8.push_back(dot(xs, 0, 8));
        q8.push_back(dot(xs, 16, 8));
        play8(xs, 32'h1);
        drain("extremes");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_bit1();
        test_back_to_back();
        test_gapped();
        test_sync_abort();
        test_sync_last();
        test_reset_mid();
        test_extremes();
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
